// File: rtl/gonso_pkg.sv
// Shared definitions for the gonso register bank: register offsets, CTRL/STATUS
// bit positions, sequencer state encoding and the byte-lane merge helper.
package gonso_pkg;

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_INC    = 8'h08;
    localparam logic [7:0] OFF_CH_IN  = 8'h20;
    localparam logic [7:0] OFF_CH_OUT = 8'h40;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_START_BIT  = 2;
    localparam int CTRL_MASK_LSB   = 8;

    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_DONE_BIT = 1;
    localparam int STAT_OVF_LSB  = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_e;

    // Replace only the byte lanes enabled in sel, keep the rest of old.
    function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                              input logic [31:0] wdat,
                                              input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = wdat[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/gonso_seq.sv
// Channel sequencer: walks idx over the snapshotted mask, producing in+INC per
// channel with carry flags. GONSO_SATURATE_EN clamps the result on carry.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for an accepted start command
// ST_RUN  | one channel per cycle, idx 0..NUM_CH-1, then done pulse
module gonso_seq
    import gonso_pkg::*;
#(
    parameter int DATA_W = 20,
    parameter int NUM_CH = 4,
    parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start_i,
    input  logic                           enable_i,
    input  logic [NUM_CH-1:0]              mask_i,
    input  logic [NUM_CH-1:0][DATA_W-1:0]  ch_in_i,
    input  logic [DATA_W-1:0]              inc_i,
    output logic                           busy_o,
    output logic                           done_set_o,
    output logic                           out_we_o,
    output logic [IDX_W-1:0]               out_idx_o,
    output logic [DATA_W-1:0]              out_data_o,
    output logic [NUM_CH-1:0]              ovf_o
);

    seq_state_e          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [NUM_CH-1:0]   ovf_q, ovf_d;
    logic [DATA_W:0]     sum;
    logic                carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            mask_q  <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        sum   = {1'b0, ch_in_i[idx_q]} + {1'b0, inc_i};
        carry = sum[DATA_W];
`ifdef GONSO_SATURATE_EN
        out_data_o = carry ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
`else
        out_data_o = sum[DATA_W-1:0];
`endif
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mask_d     = mask_q;
        ovf_d      = ovf_q;
        done_set_o = 1'b0;
        out_we_o   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                    mask_d  = mask_i;
                    ovf_d   = '0;
                end
            end
            ST_RUN: begin
                // Dropping enable abandons the pass without flagging completion.
                if (!enable_i) begin
                    state_d = ST_IDLE;
                end else begin
                    if (mask_q[idx_q]) begin
                        out_we_o     = 1'b1;
                        ovf_d[idx_q] = carry;
                    end
                    if (idx_q == IDX_W'(NUM_CH - 1)) begin
                        state_d    = ST_IDLE;
                        done_set_o = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_o    = (state_q == ST_RUN);
    assign out_idx_o = idx_q;
    assign ovf_o     = ovf_q;

endmodule

// File: rtl/gonso_regbank.sv
// Wishbone register bank with NUM_CH input/result pairs and a shared increment.
// Saturating add is selected at compile time with GONSO_SATURATE_EN.
module gonso_regbank
    import gonso_pkg::*;
#(
    parameter int          DATA_W    = 20,
    parameter int          NUM_CH    = 4,
    parameter logic [31:0] BASE_ADDR = 32'h3003_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic [31:0] wishbone_address,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        irq,
    output logic        busy
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                          ack_q, ack_d;
    logic [31:0]                   dat_q, dat_d;
    logic                          irq_q, irq_d;
    logic                          enable_q, enable_d;
    logic                          irq_en_q, irq_en_d;
    logic [NUM_CH-1:0]             mask_q, mask_d;
    logic                          done_q, done_d;
    logic [DATA_W-1:0]             inc_q, inc_d;
    logic [NUM_CH-1:0][DATA_W-1:0] ch_in_q, ch_in_d;
    logic [NUM_CH-1:0][DATA_W-1:0] ch_out_q, ch_out_d;

    logic        window_hit, access, wr;
    logic [7:0]  off;
    logic [31:0] rdata, merged, ctrl_cur;
    logic        start_go;

    logic                  seq_busy, seq_done_set, seq_out_we;
    logic [IDX_W-1:0]      seq_out_idx;
    logic [DATA_W-1:0]     seq_out_data;
    logic [NUM_CH-1:0]     seq_ovf;

    assign window_hit = (wishbone_address[31:8] == BASE_ADDR[31:8]);
    assign access     = wbs_cyc_i & wbs_stb_i & window_hit & ~ack_q;
    assign wr         = access & wbs_we_i;
    assign off        = {wishbone_address[7:2], 2'b00};

    always_comb begin
        ctrl_cur                            = '0;
        ctrl_cur[CTRL_EN_BIT]               = enable_q;
        ctrl_cur[CTRL_IRQ_EN_BIT]           = irq_en_q;
        ctrl_cur[CTRL_MASK_LSB +: NUM_CH]   = mask_q;
    end

    always_comb begin
        rdata = '0;
        case (off)
            OFF_CTRL: rdata = ctrl_cur;
            OFF_STATUS: begin
                rdata[STAT_BUSY_BIT]            = seq_busy;
                rdata[STAT_DONE_BIT]            = done_q;
                rdata[STAT_OVF_LSB +: NUM_CH]   = seq_ovf;
            end
            OFF_INC: rdata = 32'(inc_q);
            default: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (off == OFF_CH_IN + 8'(4 * i))  rdata = 32'(ch_in_q[i]);
                    if (off == OFF_CH_OUT + 8'(4 * i)) rdata = 32'(ch_out_q[i]);
                end
            end
        endcase
    end

    // Read-modify-write image of the addressed register; unused bits read 0,
    // so masking through rdata also discards writes to unimplemented fields.
    assign merged = apply_sel(rdata, wbs_dat_i, wbs_sel_i);

    always_comb begin
        enable_d = enable_q;
        irq_en_d = irq_en_q;
        mask_d   = mask_q;
        inc_d    = inc_q;
        ch_in_d  = ch_in_q;
        if (wr && off == OFF_CTRL) begin
            enable_d = merged[CTRL_EN_BIT];
            irq_en_d = merged[CTRL_IRQ_EN_BIT];
            mask_d   = merged[CTRL_MASK_LSB +: NUM_CH];
        end
        if (wr && off == OFF_INC) inc_d = merged[DATA_W-1:0];
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr && off == OFF_CH_IN + 8'(4 * i)) ch_in_d[i] = merged[DATA_W-1:0];
        end
    end

    // Start qualifies against the enable value being written in the same access.
    assign start_go = wr && (off == OFF_CTRL) && wbs_sel_i[0]
                      && wbs_dat_i[CTRL_START_BIT] && enable_d && !seq_busy;

    always_comb begin
        done_d = done_q;
        if (wr && off == OFF_STATUS && wbs_sel_i[0] && wbs_dat_i[STAT_DONE_BIT]) done_d = 1'b0;
        if (start_go) done_d = 1'b0;
        if (seq_done_set) done_d = 1'b1;
    end

    always_comb begin
        ch_out_d = ch_out_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (seq_out_we && seq_out_idx == IDX_W'(i)) ch_out_d[i] = seq_out_data;
        end
    end

    always_comb begin
        ack_d = access;
        dat_d = (access && !wbs_we_i) ? rdata : 32'h0;
        irq_d = done_q & irq_en_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            irq_q    <= 1'b0;
            enable_q <= 1'b0;
            irq_en_q <= 1'b0;
            mask_q   <= '0;
            done_q   <= 1'b0;
            inc_q    <= '0;
            ch_in_q  <= '0;
            ch_out_q <= '0;
        end else begin
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            irq_q    <= irq_d;
            enable_q <= enable_d;
            irq_en_q <= irq_en_d;
            mask_q   <= mask_d;
            done_q   <= done_d;
            inc_q    <= inc_d;
            ch_in_q  <= ch_in_d;
            ch_out_q <= ch_out_d;
        end
    end

    gonso_seq #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_go),
        .enable_i   (enable_q),
        .mask_i     (mask_d),
        .ch_in_i    (ch_in_q),
        .inc_i      (inc_q),
        .busy_o     (seq_busy),
        .done_set_o (seq_done_set),
        .out_we_o   (seq_out_we),
        .out_idx_o  (seq_out_idx),
        .out_data_o (seq_out_data),
        .ovf_o      (seq_ovf)
    );

    logic unused_bits;
    assign unused_bits = ^{wishbone_address[1:0], merged};

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq       = irq_q;
    assign busy      = seq_busy;

endmodule

// File: tb/tb_gonso_regbank.sv
// Scoreboarded bench for gonso_regbank: bus reads push expected data taken from
// a register-level model; a monitor compares on every ack.
module tb_gonso_regbank;

    localparam int          DATA_W = 20;
    localparam int          NUM_CH = 4;
    localparam logic [31:0] BASE   = 32'h3003_0000;
    localparam logic [31:0] DMASK  = (DATA_W == 32) ? 32'hFFFF_FFFF : ((32'h1 << DATA_W) - 32'h1);
    localparam logic [31:0] CMASK  = (32'h1 << NUM_CH) - 32'h1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] adr = '0, dat_i = '0;
    logic [3:0]  sel = '0;
    logic [31:0] dat_o;
    logic        ack, irq, busy;

    gonso_regbank #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb),
        .wishbone_address(adr), .wbs_we_i(we), .wbs_dat_i(dat_i), .wbs_sel_i(sel),
        .wbs_dat_o(dat_o), .wbs_ack_o(ack), .irq(irq), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_rd;
        logic [31:0] addr;
        logic [31:0] exp;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Register-level model
    logic [31:0] m_in[NUM_CH];
    logic [31:0] m_out[NUM_CH];
    logic [31:0] m_inc;
    logic        m_en, m_irqen, m_done;
    logic [31:0] m_mask, m_ovf, m_run_mask;

    task automatic m_reset();
        for (int i = 0; i < NUM_CH; i++) begin m_in[i] = 0; m_out[i] = 0; end
        m_inc = 0; m_en = 0; m_irqen = 0; m_done = 0;
        m_mask = 0; m_ovf = 0; m_run_mask = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [7:0] off);
        if (off == 8'h00) return {16'h0, m_mask[7:0], 6'h0, m_irqen, m_en};
        if (off == 8'h04) return {16'h0, m_ovf[7:0], 6'h0, m_done, 1'b0};
        if (off == 8'h08) return m_inc;
        for (int i = 0; i < NUM_CH; i++) begin
            if (off == 8'h20 + 8'(4 * i)) return m_in[i];
            if (off == 8'h40 + 8'(4 * i)) return m_out[i];
        end
        return 32'h0;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] bm;
        bm = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~bm) | (d & bm);
    endfunction

    task automatic m_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mg;
        mg = merge(m_read(off), d, s);
        if (off == 8'h00) begin
            m_en = mg[0]; m_irqen = mg[1]; m_mask = (mg >> 8) & CMASK;
            if (s[0] && d[2] && m_en) begin
                m_run_mask = m_mask; m_ovf = 0; m_done = 0;
            end
        end else if (off == 8'h04) begin
            if (s[0] && d[1]) m_done = 0;
        end else if (off == 8'h08) begin
            m_inc = mg & DMASK;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                if (off == 8'h20 + 8'(4 * i)) m_in[i] = mg & DMASK;
        end
    endtask

    // Process the first n channels of the pending pass; a full pass sets done.
    task automatic m_run(input int n);
        logic [63:0] s;
        for (int i = 0; i < n; i++) begin
            if (m_run_mask[i]) begin
                s = 64'(m_in[i]) + 64'(m_inc);
                m_ovf[i] = (s > 64'(DMASK));
`ifdef GONSO_SATURATE_EN
                m_out[i] = m_ovf[i] ? DMASK : s[31:0];
`else
                m_out[i] = s[31:0] & DMASK;
`endif
            end
        end
        if (n == NUM_CH) m_done = 1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && ack) begin
            if (sbq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_ack addr=%h got=1 want=0", adr);
            end else begin
                mon_e = sbq.pop_front();
                if (mon_e.is_rd) begin
                    checks++;
                    if (dat_o !== mon_e.exp) begin
                        errors++;
                        $display("FAIL read addr=%h got=%h want=%h", mon_e.addr, dat_o, mon_e.exp);
                    end
                end
            end
        end
    end

    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic exp_ack, input logic [31:0] exp_rd);
        exp_t e;
        logic got;
        @(negedge clk);
        if (exp_ack) begin
            e.is_rd = ~w; e.addr = a; e.exp = exp_rd;
            sbq.push_back(e);
        end
        cyc = 1; stb = 1; we = w; adr = a; dat_i = d; sel = s;
        got = 0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            if (ack) begin got = 1; break; end
        end
        cyc = 0; stb = 0; we = 0;
        chk("ack_seen", 32'(got), 32'(exp_ack));
        if (exp_ack && !got) void'(sbq.pop_back());
    endtask

    task automatic rd(input logic [7:0] off);
        bus(0, BASE + 32'(off), 32'h0, 4'hF, 1, m_read(off));
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
        bus(1, BASE + 32'(off), d, s, 1, 32'h0);
        m_write(off, d, s);
    endtask

    task automatic measure(output int t_idle, output int t_irq);
        t_idle = -1; t_irq = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (t_idle < 0 && !busy) t_idle = c;
            if (t_irq < 0 && irq) t_irq = c;
        end
    endtask

    task automatic read_all();
        rd(8'h00); rd(8'h04);
        for (int i = 0; i < NUM_CH; i++) rd(8'h40 + 8'(4 * i));
    endtask

    initial begin
        int ti, tq;
        logic [7:0] unm[7];
        unm = '{8'h0C, 8'h10, 8'h1C, 8'h30, 8'h5C, 8'h80, 8'hFC};
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 32'(ack), 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_busy", 32'(busy), 0);
        @(negedge clk) rst_n = 1;
        rd(8'h00); rd(8'h04); rd(8'h40);

        // basic pass, no carry
        wr(8'h08, 32'h1, 4'hF);
        wr(8'h20, 32'h12345, 4'hF);
        wr(8'h00, 32'h0F05, 4'hF);
        m_run(NUM_CH);
        chk("busy_at_start_ack", 32'(busy), 1);
        measure(ti, tq);
        chk("done_latency", 32'(ti), NUM_CH);
        chk("irq_off_when_disabled", 32'(tq), 32'hFFFF_FFFF);
        rd(8'h40); rd(8'h04);

        // carry on channel 1
        wr(8'h24, 32'hFFFFF, 4'hF);
        wr(8'h08, 32'h2, 4'hF);
        wr(8'h00, 32'h0F05, 4'hF);
        m_run(NUM_CH);
        repeat (NUM_CH + 2) @(posedge clk);
        rd(8'h44); rd(8'h04);

        // masked pass with interrupt
        wr(8'h24, 32'h10, 4'hF);
        wr(8'h2C, 32'h100, 4'hF);
        wr(8'h00, 32'h0507, 4'hF);
        m_run(NUM_CH);
        measure(ti, tq);
        chk("masked_done_latency", 32'(ti), NUM_CH);
        chk("irq_latency", 32'(tq), NUM_CH + 1);
        read_all();
        wr(8'h04, 32'h2, 4'hF);
        chk("irq_held_at_clear_ack", 32'(irq), 1);
        @(posedge clk); #1;
        chk("irq_after_clear", 32'(irq), 0);

        // abort two cycles into a pass
        wr(8'h28, 32'h11, 4'hF);
        wr(8'h2C, 32'h22, 4'hF);
        wr(8'h08, 32'h3, 4'hF);
        wr(8'h00, 32'h0F05, 4'hF);
        m_run(2);
        wr(8'h00, 32'h0F00, 4'hF);
        @(posedge clk); #1;
        chk("abort_busy", 32'(busy), 0);
        read_all();

        // byte enables and address decode
        wr(8'h20, 32'h0, 4'hF);
        wr(8'h20, 32'hFFFF_FFFF, 4'b0001);
        rd(8'h20);
        rd(8'hFC);
        bus(0, BASE + 32'h100, 32'h0, 4'hF, 0, 32'h0);
        bus(1, 32'h3004_0000, 32'hFFFF_FFFF, 4'hF, 0, 32'h0);

        // randomized passes
        for (int it = 0; it < 12; it++) begin
            int nw;
            logic [7:0] o;
            nw = $urandom_range(1, 4);
            for (int k = 0; k < nw; k++) begin
                int t;
                t = $urandom_range(0, NUM_CH + 1);
                if (t == NUM_CH) o = 8'h08;
                else if (t == NUM_CH + 1) o = 8'h40 + 8'(4 * $urandom_range(0, NUM_CH - 1));
                else o = 8'h20 + 8'(4 * t);
                wr(o, $urandom, 4'($urandom_range(1, 15)));
            end
            o = unm[$urandom_range(0, 6)];
            wr(o, $urandom, 4'hF);
            rd(o);
            wr(8'h00, (32'($urandom_range(0, 15)) << 8) | (32'($urandom_range(0, 1)) << 1) | 32'h5, 4'b0011);
            m_run(NUM_CH);
            repeat (NUM_CH + 3) @(posedge clk);
            #1;
            chk("rand_irq", 32'(irq), 32'(m_done & m_irqen));
            read_all();
            for (int i = 0; i < NUM_CH; i++) rd(8'h20 + 8'(4 * i));
            rd(8'h08);
            if ($urandom_range(0, 1) == 1) wr(8'h04, 32'h2, 4'($urandom_range(0, 15)));
        end

        // reset in the middle of a pass
        wr(8'h00, 32'h0F07, 4'hF);
        @(posedge clk);
        @(negedge clk) rst_n = 0;
        #1;
        chk("midrun_rst_busy", 32'(busy), 0);
        chk("midrun_rst_irq", 32'(irq), 0);
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        read_all();
        rd(8'h20); rd(8'h08);

        repeat (4) @(posedge clk);
        if (sbq.size() != 0) begin
            checks++; errors++;
            $display("FAIL pending_expectations got=%0d want=0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gonso_regbank.md
# gonso_regbank

Parametrised successor to the single-channel gonso register block: a Wishbone slave holding `NUM_CH` input/result register pairs plus a shared increment, with a sequencer that computes `out[i] = in[i] + INC` channel by channel on command. It sits between the Caravel Wishbone bus and user logic, reports completion via a sticky status flag, and raises a level interrupt. Result width, channel count and base address are parameters; saturation is a compile-time option.

## Interface
- `DATA_W`, 20: width of CH_IN, CH_OUT and INC registers (1..32).
- `NUM_CH`, 4: number of channels (1..8).
- `BASE_ADDR`, 32'h3003_0000: window base; bits [7:0] must be zero.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `wbs_cyc_i`  in  1  Wishbone cycle.
- `wbs_stb_i`  in  1  Wishbone strobe.
- `wishbone_address`  in  32  byte address.
- `wbs_we_i`  in  1  1 = write.
- `wbs_dat_i`  in  32  write data.
- `wbs_sel_i`  in  4  byte enables.
- `wbs_dat_o`  out  32  read data, registered.
- `wbs_ack_o`  out  1  acknowledge.
- `irq`  out  1  interrupt, level.
- `busy`  out  1  sequencer running.

## Operation
- Map (offset from BASE_ADDR): 0x00 CTRL, 0x04 STATUS, 0x08 INC, 0x20+4i CH_IN[i], 0x40+4i CH_OUT[i] (read-only).
- CTRL: [0] enable, [1] irq_en, [2] start (write-1 pulse, reads 0), [8+:NUM_CH] ch_mask.
- STATUS: [0] busy (RO), [1] done (sticky, write-1-clear), [8+:NUM_CH] ovf per channel (RO, cleared at start).
- Writes honour `wbs_sel_i` per byte; bits above DATA_W / unused fields read 0, writes ignored.
- Access outside window (address[31:8] ≠ BASE_ADDR[31:8]): no ack. In-window unmapped offset: ack, read 0, write ignored.
- FSM IDLE → RUN on start write with enable=1 (the new CTRL value); ch_mask snapshotted, idx=0, ovf cleared, done cleared.
- RUN: each cycle, if mask[idx], CH_OUT[idx] ← in[idx]+INC and ovf[idx] ← carry; idx++. After idx = NUM_CH−1 → IDLE, done ← 1.
- CH_IN/INC read live at the cycle a channel is processed (bus write in the same cycle is seen next cycle).
- start while busy: ignored. enable cleared while RUN: → IDLE next cycle, done not set, processed channels keep results.
- Write-1 to done in the same cycle as done is set: set wins.
- irq = done & irq_en (registered).

## Timing
- Reset: wbs_dat_o=0, wbs_ack_o=0, irq=0, busy=0; all registers 0, FSM IDLE.
- Ack asserted the cycle after valid (cyc&stb) is sampled with ack low; held exactly one cycle; back-to-back requests acked every second cycle.
- Read data valid with ack; write takes effect on the ack edge.
- Start write acked at edge T → busy=1 from T; done=1 at T+NUM_CH; irq at T+NUM_CH+1.
- Reset mid-RUN: immediate return to reset values.

## Configuration
- `GONSO_SATURATE_EN` defined: add saturates to 2^DATA_W−1 on carry, ovf still set.
- Undefined: add wraps modulo 2^DATA_W; ovf flags carry.

## Structure
- `gonso_pkg`: register offsets, CTRL/STATUS bit positions, FSM state enum.
- Sub-module `gonso_seq`: FSM, idx counter, mask snapshot, adder and ovf generation; top holds bus decode and register storage.

## Test plan
- Reset then read CTRL, STATUS, CH_OUT[0] → all 0x0000_0000; irq=0.
- DATA_W=20: write INC=1, CH_IN[0]=0x12345, CTRL=0x0F05 → CH_OUT[0]=0x12346, done at start-ack+4, STATUS=0x0002.
- CH_IN[1]=0xFFFFF, INC=2 → wrap: CH_OUT[1]=0x00001, ovf[1]=1; with GONSO_SATURATE_EN: 0xFFFFF, ovf[1]=1.
- ch_mask=0x05, irq_en=1 → only CH_OUT[0],[2] updated; irq rises at +5 cycles; write STATUS=0x2 → irq=0 next cycle.
- Write CTRL=0x0F00 (enable clear) 2 cycles after start → busy drops, done stays 0, CH_OUT[2..3] unchanged.
- sel=4'b0001 write 0xFFFF_FFFF to CH_IN[0] (was 0) → reads 0x0000_00FF; read at BASE+0xFC → 0 with ack; BASE+0x100 → no ack.
